el2_pmp_chan_arbiter: RTL and testbench
=======================================

// Module: el2_pmp_chan_arbiter
// PURPOSE
// - Shares one el2_pmp check channel (addr/type in, err out) between N_REQ requesters
//   (e.g. IFU, LSU, DMA), round-robin.
// - Sequences each check:
//   grant -> drive channel for one cycle -> register verdict -> return response.
// - Sits between the requesters and a single el2_pmp channel.
// - Counts denied accesses for debug/perf.
// PARAMETERS
// - N_REQ    default 3    number of requesters, 2..8
// - ID_W     default 2    requester-id width, $clog2(N_REQ) rounded up to >=1
// - CNT_W    default 16   deny-counter width
// PORTS
// - clk            in   1             single clock
// - rst            in   1             synchronous, active-high reset
// - req_valid      in   N_REQ         per-requester check request
// - req_ready      out  N_REQ         one-hot grant; handshake when valid&ready
// - req_addr       in   N_REQ x 32    per-requester address
// - req_type       in   N_REQ x el2_pmp_type_pkt_t   access type
// - rsp_valid      out  1             verdict available
// - rsp_ready      in   1             verdict consumed when valid&ready
// - rsp_id         out  ID_W          requester that owns the verdict
// - rsp_err        out  1             1 = access denied by PMP
// - pmp_cfg_upd    in   1             pmpcfg/pmpaddr written this cycle
// - pmp_chan_addr  out  32            to el2_pmp channel
// - pmp_chan_type  out  el2_pmp_type_pkt_t   to el2_pmp channel
// - pmp_chan_err   in   1             from el2_pmp channel, combinational
// - deny_cnt       out  CNT_W         saturating count of rsp_err handshakes
// - deny_cnt_clr   in   1             clear deny_cnt
// - busy           out  1             state != IDLE
// BEHAVIOUR
// - Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_err=0, pmp_chan_addr=0,
//   pmp_chan_type=0, deny_cnt=0, busy=0, rr_ptr=0, state=IDLE.
// - FSM IDLE -> CHECK -> RESP -> IDLE; one transaction in flight.
// - IDLE:
//   - Pick the first valid requester searching from rr_ptr upward with wrap.
//   - Assert its req_ready in the same cycle (combinational from valid).
//   - Latch addr, type and id; set rr_ptr = (id+1) mod N_REQ; go to CHECK.
//   - No valid requester -> stay in IDLE with req_ready=0.
// - CHECK:
//   - pmp_chan_addr/type are driven from the latched registers.
//   - At the clock edge, sample pmp_chan_err into rsp_err; go to RESP.
//   - If pmp_cfg_upd=1 this cycle, discard the sample, stay in CHECK and re-check next
//     cycle. Repeats while pmp_cfg_upd stays high.
// - RESP:
//   - rsp_valid=1; rsp_id and rsp_err held stable until rsp_ready.
//   - On handshake, go to IDLE. A new grant is possible the next cycle.
//   - pmp_cfg_upd in RESP is ignored; the verdict reflects the config at check time.
// - Latency: grant at cycle T, rsp_valid at T+2 (no cfg_upd). Peak throughput is one
//   check per 3 cycles.
// - req_ready is 0 in CHECK and RESP; at most one bit set, and never without its
//   req_valid.
// - pmp_chan_addr/type hold their last values outside CHECK.
// - Requester dropping req_valid before its grant: legal, it is simply not granted.
// - deny_cnt:
//   - +1 on each rsp_valid&rsp_ready&rsp_err.
//   - Saturates at 2^CNT_W-1.
//   - deny_cnt_clr has priority over an increment in the same cycle (result 0).
// - rst asserted in any state: FSM returns to IDLE next edge; any in-flight
//   transaction is dropped with no response; rr_ptr=0.
// STRUCTURE
// - el2_pkg gains:
//   - typedef enum logic [1:0] {PMPA_IDLE, PMPA_CHECK, PMPA_RESP} el2_pmp_arb_state_e
//   - localparam PMPA_MAX_REQ = 8
// - Reuse el2_pmp_type_pkt_t from el2_pkg.
// - Sub-module el2_pmp_rr_pick: combinational round-robin one-hot picker
//   (req vector + pointer -> grant vector + id).
// - FSM, latches and counter stay in the top module.
// TESTING
// - Single request: req0 addr 0x8000_0000 into a denying region.
//   -> req_ready[0] at T, rsp_valid at T+2, rsp_id=0, rsp_err=1, deny_cnt=1.
// - Fairness: all 3 requesters held valid for 9 checks.
//   -> grant order 0,1,2,0,1,2,0,1,2; each requester gets 3 grants.
// - Back-pressure: rsp_ready=0 for 5 cycles in RESP.
//   -> rsp_valid/id/err stable; req_ready stays 0; completes on the 6th cycle.
// - Config race: pmp_cfg_upd=1 for 2 cycles during CHECK, region flipped from deny
//   to allow. -> rsp_valid at T+4, rsp_err=0.
// - Counter: 2^CNT_W+3 denials -> saturates at max. Clear coinciding with a denial
//   handshake -> deny_cnt=0.
// - Reset mid-RESP: rst=1 for 1 cycle. -> rsp_valid=0 next cycle, busy=0, the next
//   grant goes to requester 0.

Source files
------------

// File: rtl/el2_pmp_chan_arbiter_pkg.sv
// Shared types for the PMP channel arbiter: the access-type packet carried to the
// el2_pmp channel, the arbiter FSM states and the round-robin index helper.
package el2_pmp_chan_arbiter_pkg;

    typedef struct packed {
        logic execute;
        logic read;
        logic write;
    } el2_pmp_type_pkt_t;

    typedef enum logic [1:0] {
        PMPA_IDLE  = 2'd0,
        PMPA_CHECK = 2'd1,
        PMPA_RESP  = 2'd2
    } el2_pmp_arb_state_e;

    localparam int PMPA_MAX_REQ = 8;

    // (base + offset) mod n, for base and offset both below n.
    function automatic int wrap_idx(input int base, input int offset, input int n);
        int s;
        s = base + offset;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/el2_pmp_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping,
// returned as a one-hot grant plus its index.
module el2_pmp_rr_pick
    import el2_pmp_chan_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        // Outer loop is priority distance from ptr; inner loop finds that slot.
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!any && req[i] && (i == wrap_idx(int'(ptr), k, N_REQ))) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    id     = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/el2_pmp_chan_arbiter.sv
// Shares one el2_pmp check channel between N_REQ requesters, round-robin, with one
// check in flight: grant, drive the channel, register the verdict, hand it back.
module el2_pmp_chan_arbiter
    import el2_pmp_chan_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][31:0]         req_addr,
    input  el2_pmp_type_pkt_t [N_REQ-1:0]  req_type,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           rsp_err,
    input  logic                           pmp_cfg_upd,
    output logic [31:0]                    pmp_chan_addr,
    output el2_pmp_type_pkt_t              pmp_chan_type,
    input  logic                           pmp_chan_err,
    output logic [CNT_W-1:0]               deny_cnt,
    input  logic                           deny_cnt_clr,
    output logic                           busy,
    output el2_pmp_arb_state_e             dbg_state
);

    // Handshakes: a request transfers on the cycle req_valid[i] & req_ready[i] are both
    // high; a verdict transfers on rsp_valid & rsp_ready. Valid never waits on ready.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    el2_pmp_arb_state_e r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [31:0]        r_addr;
    el2_pmp_type_pkt_t  r_type;
    logic [ID_W-1:0]    r_id;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_deny_cnt;

    logic [N_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_any;
    logic               w_grant;
    logic [31:0]        w_sel_addr;
    el2_pmp_type_pkt_t  w_sel_type;
    logic               w_rsp_hs;

    el2_pmp_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .gnt (w_gnt),
        .id  (w_gnt_id),
        .any (w_any)
    );

    assign w_grant   = (r_state == PMPA_IDLE) && w_any;
    assign req_ready = (w_grant && !rst) ? w_gnt : '0;
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;

    always_comb begin
        w_sel_addr = '0;
        w_sel_type = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = req_addr[i];
                w_sel_type = req_type[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PMPA_IDLE;
            r_rr_ptr    <= '0;
            r_addr      <= '0;
            r_type      <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                PMPA_IDLE: begin
                    if (w_grant) begin
                        r_addr   <= w_sel_addr;
                        r_type   <= w_sel_type;
                        r_id     <= w_gnt_id;
                        r_rr_ptr <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
                        r_state  <= PMPA_CHECK;
                    end
                end
                PMPA_CHECK: begin
                    // A config write this cycle may race the channel result; re-check.
                    if (!pmp_cfg_upd) begin
                        r_rsp_err   <= pmp_chan_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= PMPA_RESP;
                    end
                end
                PMPA_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= PMPA_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= PMPA_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || deny_cnt_clr) begin
            r_deny_cnt <= '0;
        end else if (w_rsp_hs && r_rsp_err && (r_deny_cnt != CNT_MAX)) begin
            r_deny_cnt <= r_deny_cnt + CNT_W'(1);
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_id;
    assign rsp_err       = r_rsp_err;
    assign pmp_chan_addr = r_addr;
    assign pmp_chan_type = r_type;
    assign deny_cnt      = r_deny_cnt;
    assign busy          = (r_state != PMPA_IDLE);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_el2_pmp_chan_arbiter.sv
// Bench for el2_pmp_chan_arbiter: a toy PMP answers the channel, and a transaction-level
// model (round-robin pointer, verdict queue, saturating counter) predicts every response.
module tb_el2_pmp_chan_arbiter;
    import el2_pmp_chan_arbiter_pkg::*;

    localparam int N_REQ   = 3;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic                          clk;
    logic                          rst;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ-1:0][31:0]        req_addr;
    el2_pmp_type_pkt_t [N_REQ-1:0] req_type;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic                          rsp_err;
    logic                          pmp_cfg_upd;
    logic [31:0]                   pmp_chan_addr;
    el2_pmp_type_pkt_t             pmp_chan_type;
    logic                          pmp_chan_err;
    logic [CNT_W-1:0]              deny_cnt;
    logic                          deny_cnt_clr;
    logic                          busy;
    el2_pmp_arb_state_e            dbg_state;

    // Toy PMP: a switchable region at 0x8xxx_xxxx, elsewhere writes to odd 16B blocks deny.
    logic region_deny;

    function automatic logic pmp_deny(input logic [31:0] a, input el2_pmp_type_pkt_t t,
                                      input logic region);
        if (a[31:28] == 4'h8) begin
            return region;
        end
        return a[4] & t.write;
    endfunction

    assign pmp_chan_err = pmp_deny(pmp_chan_addr, pmp_chan_type, region_deny);

    el2_pmp_chan_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_type      (req_type),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_err       (rsp_err),
        .pmp_cfg_upd   (pmp_cfg_upd),
        .pmp_chan_addr (pmp_chan_addr),
        .pmp_chan_type (pmp_chan_type),
        .pmp_chan_err  (pmp_chan_err),
        .deny_cnt      (deny_cnt),
        .deny_cnt_clr  (deny_cnt_clr),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Model and scoreboard
    int n_checks;
    int n_errors;
    int m_ptr;
    int m_cnt;
    int grant_hist[N_REQ];
    int grant_log[$];
    logic [ID_W:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N_REQ-1:0] mask);
        for (int k = 0; k < N_REQ; k++) begin
            if (mask[(m_ptr + k) % N_REQ]) begin
                return (m_ptr + k) % N_REQ;
            end
        end
        return -1;
    endfunction

    // Driver tasks
    task automatic apply_reset();
        @(posedge clk); #1;
        rst          = 1'b1;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        pmp_cfg_upd  = 1'b0;
        deny_cnt_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        m_ptr = 0;
        m_cnt = 0;
        exp_q.delete();
        grant_log.delete();
        for (int i = 0; i < N_REQ; i++) grant_hist[i] = 0;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_chan_addr", pmp_chan_addr, 32'd0);
        check_eq("rst_chan_type", 32'(pmp_chan_type), 32'd0);
        check_eq("rst_deny_cnt", 32'(deny_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
    endtask

    // One full transaction. bp = RESP cycles with rsp_ready low, upd = CHECK cycles with
    // pmp_cfg_upd high, flip toggles the region during the last upd cycle.
    task automatic do_txn(input logic [N_REQ-1:0] mask, input int bp, input int upd,
                          input logic flip, input logic clr, input logic rst_resp,
                          output int w);
        logic [N_REQ-1:0] exp_oh;
        logic [ID_W:0]    exp_rsp;
        logic             exp_err;

        @(posedge clk); #1;
        req_valid    = mask;
        rsp_ready    = 1'b0;
        pmp_cfg_upd  = 1'b0;
        deny_cnt_clr = 1'b0;
        @(negedge clk);
        w = pick(mask);
        exp_oh = '0;
        exp_oh[w] = 1'b1;
        check_eq("grant", 32'(req_ready), 32'(exp_oh));
        check_eq("grant_busy", 32'(busy), 32'd0);
        m_ptr = (w + 1) % N_REQ;
        grant_hist[w]++;
        grant_log.push_back(w);

        for (int c = 0; c <= upd; c++) begin
            @(posedge clk); #1;
            pmp_cfg_upd = (c < upd);
            if (flip && upd > 0 && c == upd - 1) region_deny = ~region_deny;
            @(negedge clk);
            check_eq("chk_ready", 32'(req_ready), 32'd0);
            check_eq("chk_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("chk_busy", 32'(busy), 32'd1);
            check_eq("chk_chan_addr", pmp_chan_addr, req_addr[w]);
            check_eq("chk_chan_type", 32'(pmp_chan_type), 32'(req_type[w]));
        end
        exp_err = pmp_deny(req_addr[w], req_type[w], region_deny);
        exp_q.push_back({ID_W'(w), exp_err});

        exp_rsp = exp_q.pop_front();
        for (int c = 0; c <= bp; c++) begin
            @(posedge clk); #1;
            pmp_cfg_upd  = 1'($urandom_range(0, 1));
            rsp_ready    = (c == bp) && !rst_resp;
            rst          = (c == bp) && rst_resp;
            deny_cnt_clr = (c == bp) && clr;
            @(negedge clk);
            check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("rsp_id", 32'(rsp_id), 32'(exp_rsp[ID_W:1]));
            check_eq("rsp_err", 32'(rsp_err), 32'(exp_rsp[0]));
            check_eq("rsp_req_ready", 32'(req_ready), 32'd0);
        end

        if (rst_resp) begin
            m_ptr = 0;
            if (clr) m_cnt = 0;
            else m_cnt = 0;
        end else if (clr) begin
            m_cnt = 0;
        end else if (exp_rsp[0] && m_cnt < CNT_SAT) begin
            m_cnt++;
        end

        @(posedge clk); #1;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        rst          = 1'b0;
        pmp_cfg_upd  = 1'b0;
        deny_cnt_clr = 1'b0;
        @(negedge clk);
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_busy", 32'(busy), 32'd0);
        check_eq("post_deny_cnt", 32'(deny_cnt), 32'(m_cnt));
        check_eq("post_req_ready", 32'(req_ready), 32'd0);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [2:0] t);
        req_addr[i] = a;
        req_type[i] = el2_pmp_type_pkt_t'(t);
    endtask

    initial begin
        int w;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        req_valid    = '0;
        req_addr     = '0;
        req_type     = '0;
        rsp_ready    = 1'b0;
        pmp_cfg_upd  = 1'b0;
        deny_cnt_clr = 1'b0;
        region_deny  = 1'b1;
        m_ptr        = 0;
        m_cnt        = 0;

        apply_reset();

        // Single denied request from requester 0
        set_req(0, 32'h8000_0000, 3'b010);
        do_txn(3'b001, 0, 0, 1'b0, 1'b0, 1'b0, w);
        check_eq("single_deny_cnt", 32'(deny_cnt), 32'd1);

        // Fairness with all requesters held valid
        apply_reset();
        set_req(1, 32'h0000_1000, 3'b100);
        set_req(2, 32'h0000_1010, 3'b001);
        for (int n = 0; n < 9; n++) do_txn(3'b111, 0, 0, 1'b0, 1'b0, 1'b0, w);
        for (int n = 0; n < 9; n++) check_eq("fair_order", 32'(grant_log[n]), 32'(n % 3));
        for (int i = 0; i < N_REQ; i++) check_eq("fair_count", 32'(grant_hist[i]), 32'd3);

        // Back-pressure: five stalled RESP cycles, handshake on the sixth
        do_txn(3'b010, 5, 0, 1'b0, 1'b0, 1'b0, w);

        // Config race: update for two CHECK cycles flips the region deny -> allow
        region_deny = 1'b1;
        do_txn(3'b001, 0, 2, 1'b1, 1'b0, 1'b0, w);
        check_eq("race_allow", 32'(rsp_err), 32'd0);

        // Counter saturation, then clear coinciding with a denial handshake
        apply_reset();
        region_deny = 1'b1;
        for (int n = 0; n < CNT_SAT + 4; n++) do_txn(3'b001, 0, 0, 1'b0, 1'b0, 1'b0, w);
        check_eq("cnt_saturated", 32'(deny_cnt), 32'(CNT_SAT));
        do_txn(3'b001, 1, 0, 1'b0, 1'b1, 1'b0, w);
        check_eq("cnt_clear_wins", 32'(deny_cnt), 32'd0);

        // Reset during RESP drops the verdict and restarts round-robin at 0
        do_txn(3'b010, 2, 0, 1'b0, 1'b0, 1'b1, w);
        do_txn(3'b111, 0, 0, 1'b0, 1'b0, 1'b0, w);
        check_eq("post_rst_grant", 32'(w), 32'd0);

        // Idle cycle with no requests stays idle
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check_eq("idle_ready", 32'(req_ready), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 1) == 1) a[31:28] = 4'h8;
                else a[31:28] = 4'h1;
                set_req(i, a, 3'($urandom_range(0, 7)));
            end
            region_deny = 1'($urandom_range(0, 1));
            do_txn(3'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'b0, w);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
